// File: rtl/nios2_oci_trace_packer_if.sv
// Trace packer stream bundle: the incoming slot stream and the outgoing
// packed-word ready/valid handshake.
//   in_valid/in_data             : one trace slot per cycle into the packer
//   out_valid/out_ready          : FIFO head handshake
//   out_data/out_count           : packed word at FIFO head and its slot count
// slave modport is the packer side, master the producer/consumer side.
interface nios2_oci_trace_packer_if #(
  parameter int unsigned SLOT_W = 10,
  parameter int unsigned SLOTS  = 3,
  parameter int unsigned CNT_W  = 4
);
  logic                      in_valid;
  logic [SLOT_W-1:0]         in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SLOTS*SLOT_W-1:0]   out_data;
  logic [CNT_W-1:0]          out_count;

  modport slave  (input  in_valid, in_data, out_ready,
                  output out_valid, out_data, out_count);
  modport master (output in_valid, in_data, out_ready,
                  input  out_valid, out_data, out_count);
endinterface

// File: rtl/nios2_oci_trace_packer.sv
// Packs SLOT_W-bit trace slots into SLOTS-wide words and queues them in a
// DEPTH-entry FIFO. test_ending flushes a partial word once, then capture ends.
//   clk, reset_n        : clock, asynchronous active-low reset
//   bus (slave)         : slot input stream and packed-word output handshake
//   test_ending         : one-cycle request to flush and stop capture
//   dct_buffer/count    : partial packing buffer and its slot count
//   test_has_ended      : capture ended and FIFO drained
//   overflow            : sticky, a word was dropped on a full FIFO
module nios2_oci_trace_packer #(
  parameter int unsigned SLOT_W = 10,
  parameter int unsigned SLOTS  = 3,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nios2_oci_trace_packer_if.slave bus,
  input  logic                    test_ending,
  output logic [SLOTS*SLOT_W-1:0] dct_buffer,
  output logic [CNT_W-1:0]        dct_count,
  output logic                    test_has_ended,
  output logic                    overflow
);
  localparam int unsigned WORD_W = SLOTS * SLOT_W;
  localparam int unsigned AW     = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN, FLUSH, ENDED} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] mem_q  [DEPTH];
  logic [WORD_W-1:0] mem_d  [DEPTH];
  logic [CNT_W-1:0]  mcnt_q [DEPTH];
  logic [CNT_W-1:0]  mcnt_d [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;

  logic              empty, full, pop, push, push_ok;
  logic [WORD_W-1:0] push_data;
  logic [CNT_W-1:0]  push_cnt;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_data = '0;
    push_cnt  = '0;
    case (state_q)
      RUN: begin
        if (bus.in_valid) begin
          for (int unsigned i = 0; i < SLOTS; i++) begin
            if (cnt_q == CNT_W'(i)) buf_d[i*SLOT_W +: SLOT_W] = bus.in_data;
          end
          if (cnt_q == CNT_W'(SLOTS - 1)) begin
            push      = 1'b1;
            push_data = buf_d;
            push_cnt  = CNT_W'(SLOTS);
            buf_d     = '0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (test_ending) state_d = FLUSH;
      end
      FLUSH: begin
        if (cnt_q != '0) begin
          push      = 1'b1;
          push_data = buf_q;
          push_cnt  = cnt_q;
        end
        buf_d   = '0;
        cnt_d   = '0;
        state_d = ENDED;
      end
      default: state_d = ENDED;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    mcnt_d   = mcnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // A same-cycle pop frees the slot a full-FIFO push needs.
    push_ok  = push && (!full || pop);
    ovf_d    = ovf_q || (push && !push_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]]  = push_data;
      mcnt_d[wr_ptr_q[AW-1:0]] = push_cnt;
      wr_ptr_d                 = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      buf_q    <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
      mcnt_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      mcnt_q   <= mcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.out_valid  = !empty;
  assign bus.out_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.out_count  = empty ? '0 : mcnt_q[rd_ptr_q[AW-1:0]];
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_has_ended = (state_q == ENDED) && empty;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_nios2_oci_trace_packer.sv
module tb_nios2_oci_trace_packer;
  localparam int unsigned SLOT_W = 10;
  localparam int unsigned SLOTS  = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = SLOTS * SLOT_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              test_ending = 1'b0;
  logic [WORD_W-1:0] dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              test_has_ended;
  logic              overflow;

  nios2_oci_trace_packer_if #(.SLOT_W(SLOT_W), .SLOTS(SLOTS), .CNT_W(CNT_W)) bus ();

  nios2_oci_trace_packer #(.SLOT_W(SLOT_W), .SLOTS(SLOTS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: queue of packed words, queue of pending slots.
  typedef struct {
    logic [WORD_W-1:0] data;
    int unsigned       cnt;
  } word_t;

  word_t             m_fifo[$];
  logic [SLOT_W-1:0] m_slots[$];
  bit                m_flushing;
  bit                m_ended;
  bit                m_ovf;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] m_pack();
    logic [WORD_W-1:0] w = '0;
    for (int i = 0; i < m_slots.size(); i++)
      w = w | (WORD_W'(m_slots[i]) << (i * SLOT_W));
    return w;
  endfunction

  function automatic void m_push(input logic [WORD_W-1:0] d, input int unsigned c);
    word_t w;
    w.data = d;
    w.cnt  = c;
    if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
    else m_ovf = 1'b1;
  endfunction

  function automatic void m_reset();
    m_fifo.delete();
    m_slots.delete();
    m_flushing = 1'b0;
    m_ended    = 1'b0;
    m_ovf      = 1'b0;
  endfunction

  task automatic check_outputs();
    bit ne = (m_fifo.size() != 0);
    check_eq("out_valid", bus.out_valid, ne);
    check_eq("out_data", bus.out_data, ne ? m_fifo[0].data : '0);
    check_eq("out_count", bus.out_count, ne ? m_fifo[0].cnt : 0);
    check_eq("dct_buffer", dct_buffer, m_pack());
    check_eq("dct_count", dct_count, m_slots.size());
    check_eq("test_has_ended", test_has_ended, m_ended && !ne);
    check_eq("overflow", overflow, m_ovf);
  endtask

  // Called at a falling edge: check, drive, advance model across one rising edge.
  task automatic step(input bit v, input logic [SLOT_W-1:0] d, input bit te, input bit rdy);
    check_outputs();
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    test_ending   = te;
    if (m_fifo.size() > 0 && rdy) void'(m_fifo.pop_front());
    if (m_flushing) begin
      if (m_slots.size() > 0) m_push(m_pack(), m_slots.size());
      m_slots.delete();
      m_flushing = 1'b0;
      m_ended    = 1'b1;
    end else if (!m_ended) begin
      if (v) begin
        m_slots.push_back(d);
        if (m_slots.size() == SLOTS) begin
          m_push(m_pack(), SLOTS);
          m_slots.delete();
        end
      end
      if (te) m_flushing = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b1;
    bus.in_data   = SLOT_W'($urandom);
    bus.out_ready = 1'b1;
    test_ending   = 1'b0;
    reset_n       = 1'b0;
    m_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset_n      = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    m_reset();
    @(negedge clk);

    // Three slots make one word with one cycle of latency.
    do_reset();
    step(1, 10'h001, 0, 1);
    step(1, 10'h002, 0, 1);
    step(1, 10'h003, 0, 1);
    check_eq("pack3_valid", bus.out_valid, 1);
    check_eq("pack3_data", bus.out_data, 30'h00300801);
    check_eq("pack3_count", bus.out_count, 3);
    check_eq("pack3_dct_count", dct_count, 0);
    step(0, 0, 0, 1);

    // Partial word flushed by test_ending.
    do_reset();
    step(1, 10'h0AA, 0, 0);
    step(1, 10'h155, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check_eq("flush_data", bus.out_data, 30'h000554AA);
    check_eq("flush_count", bus.out_count, 2);
    check_eq("flush_ended_early", test_has_ended, 0);
    step(0, 0, 0, 1);
    check_eq("flush_ended", test_has_ended, 1);
    step(1, 10'h3FF, 1, 1);

    // Five words into a stalled FIFO: one dropped, first four drain in order.
    do_reset();
    for (int i = 1; i <= 15; i++) step(1, SLOT_W'(i), 0, 0);
    check_eq("ovf_set", overflow, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    check_eq("ovf_drained", bus.out_valid, 0);

    // Full FIFO with a pop on the completing edge: nothing dropped.
    do_reset();
    for (int i = 1; i <= 14; i++) step(1, SLOT_W'(i + 40), 0, 0);
    step(1, 10'h07F, 0, 1);
    check_eq("full_pop_ovf", overflow, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // test_ending on the completing slot: full word only, no partial.
    do_reset();
    step(1, 10'h011, 0, 0);
    step(1, 10'h022, 0, 0);
    step(1, 10'h033, 1, 0);
    check_eq("te_full_count", bus.out_count, 3);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check_eq("te_full_ended", test_has_ended, 1);

    // Reset mid-packing with queued words.
    do_reset();
    for (int i = 1; i <= 11; i++) step(1, SLOT_W'(i * 7), 0, 0);
    do_reset();
    step(1, 10'h101, 0, 0);
    step(1, 10'h202, 0, 0);
    step(1, 10'h303, 0, 0);
    step(0, 0, 0, 0);
    check_eq("post_rst_count", bus.out_count, 3);
    step(0, 0, 0, 1);
    check_eq("post_rst_single", bus.out_valid, 0);

    // Randomized episodes.
    for (int ep = 0; ep < 30; ep++) begin
      int unsigned rdy_pct = $urandom_range(0, 100);
      int unsigned ncyc    = $urandom_range(40, 160);
      do_reset();
      for (int c = 0; c < ncyc; c++) begin
        step($urandom_range(0, 99) < 60, SLOT_W'($urandom),
             $urandom_range(0, 49) == 0, $urandom_range(0, 99) < rdy_pct);
      end
    end

    check_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/nios2_oci_trace_packer.md
NIOS2_OCI_TRACE_PACKER -- requirements
Module: nios2_oci_trace_packer

Interface
REQ-001 SHALL have parameter SLOT_W, default 10, bits per trace slot.
REQ-002 SHALL have parameter SLOTS, default 3, slots packed per output word (SLOTS >= 2).
REQ-003 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, >= 2).
REQ-004 SHALL have parameter CNT_W, default 4, slot-count field width (2^CNT_W > SLOTS).
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, trace slot present this cycle.
REQ-008 SHALL have port in_data, input, SLOT_W, trace slot payload.
REQ-009 SHALL have port test_ending, input, 1, single-cycle request to flush and end capture.
REQ-010 SHALL have port out_valid, output, 1, FIFO head valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts head.
REQ-012 SHALL have port out_data, output, SLOTS*SLOT_W, packed word at FIFO head.
REQ-013 SHALL have port out_count, output, CNT_W, valid slots in out_data.
REQ-014 SHALL have port dct_buffer, output, SLOTS*SLOT_W, current partial packing buffer.
REQ-015 SHALL have port dct_count, output, CNT_W, slots held in partial buffer.
REQ-016 SHALL have port test_has_ended, output, 1, capture finished and FIFO drained.
REQ-017 SHALL have port overflow, output, 1, sticky: at least one word dropped.

Function
REQ-018 SHALL implement FSM states RUN, FLUSH, ENDED; RUN after reset.
REQ-019 In RUN, in_valid SHALL write in_data into slot index dct_count (slot 0 at LSBs) and increment dct_count.
REQ-020 When the accepted slot makes dct_count reach SLOTS, the full word SHALL be pushed with count SLOTS, and dct_buffer/dct_count SHALL clear to 0 the same edge.
REQ-021 A pushed word SHALL appear at out_valid/out_data the cycle after the completing in_valid (1-cycle latency) when FIFO was empty.
REQ-022 out_valid SHALL equal FIFO non-empty; a pop SHALL occur on out_valid && out_ready.
REQ-023 Push when full SHALL succeed only if a pop occurs the same cycle; otherwise the word SHALL be dropped and overflow set until reset.
REQ-024 FIFO order SHALL be strictly first-in first-out; pointers SHALL wrap modulo DEPTH.
REQ-025 test_ending in RUN SHALL move to FLUSH; an in_valid in the same cycle SHALL be accepted first (including a resulting full-word push).
REQ-026 In FLUSH, if dct_count > 0, the partial word SHALL be pushed with out_count = dct_count, unused slots zero, and the partial buffer cleared; subject to REQ-023.
REQ-027 FLUSH SHALL last exactly one cycle, then move to ENDED.
REQ-028 In FLUSH and ENDED, in_valid and test_ending SHALL be ignored.
REQ-029 test_has_ended SHALL be 1 exactly when state is ENDED and FIFO is empty; draining continues in ENDED.
REQ-030 ENDED SHALL be left only by reset.
REQ-031 dct_buffer unused slots (index >= dct_count) SHALL read zero.

Reset
REQ-032 reset_n low SHALL asynchronously force: state RUN, FIFO empty, out_valid 0, out_data 0, out_count 0, dct_buffer 0, dct_count 0, test_has_ended 0, overflow 0.
REQ-033 Reset asserted mid-packing or mid-drain SHALL discard all partial and queued data; no word emitted after release until new slots arrive.
REQ-034 Deassertion SHALL be honoured on the first rising clk edge with reset_n high; no input accepted before it.

Verification
REQ-035 Defaults, out_ready=1, slots 0x001,0x002,0x003 on consecutive cycles -> next cycle out_valid=1, out_data=0x00300801, out_count=3, dct_count=0.
REQ-036 Slots 0x0AA,0x155 then test_ending -> one word out_data=0x000554AA, out_count=2; test_has_ended=1 the cycle after it pops.
REQ-037 out_ready=0, 15 slots (5 words) -> 4 words queued, overflow=1, first 4 words delivered in order when out_ready=1.
REQ-038 FIFO full, completing slot with out_ready=1 same cycle -> no drop, overflow stays 0.
REQ-039 test_ending with in_valid on the third slot -> full word count 3 pushed, no partial word, then ENDED.
REQ-040 reset_n pulsed low with 2 slots packed and 3 words queued -> all outputs zero immediately; after release, 3 new slots yield exactly one word.
